// File: rtl/cheat_pgm_pkg.sv
// Shared definitions for the cheat-engine program loader: index constants,
// record length, FSM encodings and commit-sequence helpers.
package cheat_pgm_pkg;

   localparam logic [2:0] IDX_MASK = 3'd6;
   localparam logic [2:0] IDX_CTRL = 3'd7;
   localparam int         REC_LEN  = 4;

   // Pending-write vector, in issue order: pre-mask, slots 0..5, mask, ctrl
   localparam int PEND_W     = 9;
   localparam int PEND_PRE   = 0;
   localparam int PEND_SLOT0 = 1;
   localparam int PEND_MASK  = 7;
   localparam int PEND_CTRL  = 8;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_HDR,
      RX_DATA
   } rx_state_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE_MASK,
      ST_SLOTS,
      ST_MASK,
      ST_CTRL,
      ST_DONE
   } cm_state_e;

   function automatic logic [3:0] first_pend(input logic [PEND_W-1:0] pend);
      first_pend = 4'd0;
      for (int i = PEND_W - 1; i >= 0; i--) begin
         if (pend[i]) first_pend = 4'(i);
      end
   endfunction

   function automatic cm_state_e phase_of(input logic [PEND_W-1:0] pend);
      if (pend[PEND_PRE])                       return ST_PRE_MASK;
      else if (|pend[PEND_MASK-1:PEND_SLOT0])   return ST_SLOTS;
      else if (pend[PEND_MASK])                 return ST_MASK;
      else if (pend[PEND_CTRL])                 return ST_CTRL;
      else                                      return ST_DONE;
   endfunction

endpackage

// File: rtl/cheat_pgm_loader_if.sv
// MCU / SNES-side signal bundle of the cheat program loader; the master
// drives the byte stream and bus strobe, the slave is the loader itself.
interface cheat_pgm_loader_if;

   logic        load_start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        commit;
   logic        SNES_cycle_start;
   logic [2:0]  pgm_idx;
   logic        pgm_we;
   logic [31:0] pgm_in;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output load_start, byte_in, byte_valid, commit, SNES_cycle_start,
      input  pgm_idx, pgm_we, pgm_in, busy, done, err
   );

   modport slave (
      input  load_start, byte_in, byte_valid, commit, SNES_cycle_start,
      output pgm_idx, pgm_we, pgm_in, busy, done, err
   );

endinterface

// File: rtl/cheat_pgm_rx.sv
// Record receiver: validates the header byte, counts data bytes and assembles
// the 32-bit word MSB first; emits one write per complete good record.
module cheat_pgm_rx
   import cheat_pgm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_start,
   input  logic        commit,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [2:0]  rec_idx,
   output logic [31:0] rec_word,
   output logic        rec_wr,
   output logic        hdr_err,
   output logic        mid_rec
);

   localparam logic [1:0] LAST_BYTE = 2'(REC_LEN - 1);

   rx_state_e   state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        discard_q, discard_d;
   logic [2:0]  idx_q, idx_d;
   logic [23:0] asm_q, asm_d;

   assign rec_idx  = idx_q;
   assign rec_word = {asm_q, byte_in};
   assign mid_rec  = (state_q == RX_DATA);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      discard_d = discard_q;
      idx_d     = idx_q;
      asm_d     = asm_q;
      rec_wr    = 1'b0;
      hdr_err   = 1'b0;
      // commit closes the load; load_start (re)opens it and drops any byte
      if (commit) begin
         state_d   = RX_IDLE;
         cnt_d     = 2'd0;
         discard_d = 1'b0;
      end else if (load_start) begin
         state_d   = RX_HDR;
         cnt_d     = 2'd0;
         discard_d = 1'b0;
      end else if (byte_valid) begin
         case (state_q)
            RX_HDR: begin
               idx_d     = byte_in[2:0];
               cnt_d     = 2'd0;
               state_d   = RX_DATA;
               discard_d = (byte_in[7:3] != 5'd0);
               hdr_err   = (byte_in[7:3] != 5'd0);
            end
            RX_DATA: begin
               asm_d = {asm_q[15:0], byte_in};
               if (cnt_q == LAST_BYTE) begin
                  rec_wr    = !discard_q;
                  cnt_d     = 2'd0;
                  discard_d = 1'b0;
                  state_d   = RX_HDR;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RX_IDLE;
         cnt_q     <= 2'd0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         discard_q <= discard_d;
      end
   end

   always_ff @(posedge clk) begin
      idx_q <= idx_d;
      asm_q <= asm_d;
   end

endmodule

// File: rtl/cheat_pgm_loader.sv
// MCU-side writer for the cheat engine programming port: shadows records,
// then replays dirty entries one write per SNES bus cycle on commit.
// Define CHEAT_PGM_ATOMIC_EN to bracket slot updates with mask-off/mask-restore.
module cheat_pgm_loader
   import cheat_pgm_pkg::*;
#(
   parameter int NUM_SLOTS = 6,
   parameter int WRITE_GAP = 2
)(
   input logic               clk,
   input logic               rst_n,
   cheat_pgm_loader_if.slave bus
);

   localparam int               GAP_W    = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WRITE_GAP - 1);
   localparam logic [5:0]       SLOT_EN  = 6'((1 << NUM_SLOTS) - 1);

   cm_state_e         state_q, state_d;
   logic [PEND_W-1:0] pend_q, pend_d, new_pend;
   logic [7:0]        dirty_q, dirty_d;
   logic [31:0]       mask_q, mask_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              we_q, we_d;
   logic [2:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [3:0]        sel;
   logic [31:0]       shadow_q [8];

   logic        acc_commit, acc_load, byte_ok;
   logic [2:0]  rx_idx;
   logic [31:0] rx_word;
   logic        rx_wr, rx_hdr_err, rx_mid_rec;

   // Everything from the MCU is ignored while a commit is replaying;
   // commit takes priority over a coincident load_start.
   assign acc_commit = bus.commit && !busy_q;
   assign acc_load   = bus.load_start && !bus.commit && !busy_q;
   assign byte_ok    = bus.byte_valid && !busy_q;

   cheat_pgm_rx u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (acc_load),
      .commit     (acc_commit),
      .byte_valid (byte_ok),
      .byte_in    (bus.byte_in),
      .rec_idx    (rx_idx),
      .rec_word   (rx_word),
      .rec_wr     (rx_wr),
      .hdr_err    (rx_hdr_err),
      .mid_rec    (rx_mid_rec)
   );

   function automatic logic [PEND_W-1:0] build_pend(input logic [7:0] dirty);
      logic [5:0] slots;
      slots = dirty[5:0] & SLOT_EN;
      build_pend                                = '0;
      build_pend[PEND_MASK-1:PEND_SLOT0]        = slots;
      build_pend[PEND_CTRL]                     = dirty[7];
`ifdef CHEAT_PGM_ATOMIC_EN
      build_pend[PEND_PRE]  = |slots;
      build_pend[PEND_MASK] = (|slots) | dirty[6];
`else
      build_pend[PEND_MASK] = dirty[6];
`endif
   endfunction

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      dirty_d  = dirty_q;
      mask_d   = mask_q;
      err_d    = err_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      we_d     = 1'b0;
      idx_d    = idx_q;
      word_d   = word_q;
      gap_d    = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
      sel      = first_pend(pend_q);
      new_pend = '0;

      if (rx_wr) dirty_d[rx_idx] = 1'b1;
      if (rx_hdr_err || (acc_commit && rx_mid_rec) || (bus.byte_valid && busy_q))
         err_d = 1'b1;
      if (acc_load) begin
         err_d   = 1'b0;
         dirty_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (acc_commit) begin
               new_pend = build_pend(dirty_q);
               if (new_pend == '0) begin
                  done_d = 1'b1;
               end else begin
                  pend_d  = new_pend;
                  state_d = phase_of(new_pend);
                  busy_d  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            dirty_d = '0;
            pend_d  = '0;
            state_d = ST_IDLE;
         end
         default: begin
            // One write per bus-cycle strobe, issued the clk after it
            if (bus.SNES_cycle_start && gap_q == '0) begin
               we_d    = 1'b1;
               gap_d   = GAP_LOAD;
               pend_d  = pend_q & (pend_q - PEND_W'(1));
               state_d = phase_of(pend_d);
               case (sel)
                  4'(PEND_PRE): begin
                     idx_d  = IDX_MASK;
                     word_d = '0;
                  end
                  4'(PEND_MASK): begin
                     idx_d  = IDX_MASK;
                     word_d = dirty_q[6] ? shadow_q[6] : mask_q;
                     mask_d = word_d;
                  end
                  4'(PEND_CTRL): begin
                     idx_d  = IDX_CTRL;
                     word_d = shadow_q[7];
                  end
                  default: begin
                     idx_d  = 3'(sel - 4'(PEND_SLOT0));
                     word_d = shadow_q[idx_d];
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         dirty_q <= '0;
         mask_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         word_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         dirty_q <= dirty_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         gap_q   <= gap_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_wr) shadow_q[rx_idx] <= rx_word;
   end

   assign bus.pgm_we  = we_q;
   assign bus.pgm_idx = idx_q;
   assign bus.pgm_in  = word_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_cheat_pgm_loader.sv
// Directed bench for cheat_pgm_loader; expectations follow CHEAT_PGM_ATOMIC_EN.
module tb_cheat_pgm_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cheat_pgm_loader_if bus ();

   cheat_pgm_loader #(.NUM_SLOTS(6), .WRITE_GAP(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic        strobe_en;
   logic        strb_d;
   logic [2:0]  got_idx [$];
   logic [31:0] got_word[$];
   logic [2:0]  exp_idx [$];
   logic [31:0] exp_word[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(posedge clk) strb_d <= bus.SNES_cycle_start;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.pgm_we === 1'b1) begin
         got_idx.push_back(bus.pgm_idx);
         got_word.push_back(bus.pgm_in);
         check_val("we_after_strobe", 32'(strb_d), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      bus.SNES_cycle_start = strobe_en && (cyc % 4 == 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      tick();
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_rec(input logic [7:0] hdr, input logic [31:0] word);
      send_byte(hdr);
      for (int i = 3; i >= 0; i--) send_byte(word[i*8 +: 8]);
   endtask

   task automatic pulse_load();
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
   endtask

   task automatic do_commit();
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
   endtask

   task automatic exp_wr(input logic [2:0] i, input logic [31:0] w);
      exp_idx.push_back(i);
      exp_word.push_back(w);
   endtask

   task automatic wait_done(input string tag);
      int seen = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus.done === 1'b1) begin
            seen = 1;
            break;
         end
         tick();
      end
      check_val({tag, "_done"}, 32'(seen), 32'd1);
      check_val({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic compare_writes(input string tag);
      check_val({tag, "_nwr"}, 32'(got_idx.size()), 32'(exp_idx.size()));
      for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
         check_val($sformatf("%s_idx%0d", tag, i), 32'(got_idx[i]), 32'(exp_idx[i]));
         check_val($sformatf("%s_word%0d", tag, i), got_word[i], exp_word[i]);
      end
      got_idx.delete(); got_word.delete(); exp_idx.delete(); exp_word.delete();
   endtask

   initial begin
      int got_n;
      int need;
      rst_n = 1'b0;
      bus.load_start = 1'b0; bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
      bus.commit = 1'b0; bus.SNES_cycle_start = 1'b0; strobe_en = 1'b0;
      repeat (3) tick();
      check_val("rst_we",   32'(bus.pgm_we),  32'd0);
      check_val("rst_idx",  32'(bus.pgm_idx), 32'd0);
      check_val("rst_in",   bus.pgm_in,       32'd0);
      check_val("rst_busy", 32'(bus.busy),    32'd0);
      check_val("rst_done", 32'(bus.done),    32'd0);
      check_val("rst_err",  32'(bus.err),     32'd0);
      rst_n = 1'b1;
      strobe_en = 1'b1;
      tick();

      // Single patch with mask
      pulse_load();
      send_rec(8'h00, 32'h00FFEA5C);
      send_rec(8'h06, 32'h0000_0001);
      do_commit();
      check_val("t1_busy", 32'(bus.busy), 32'd1);
`ifdef CHEAT_PGM_ATOMIC_EN
      exp_wr(3'd6, 32'h0);
`endif
      exp_wr(3'd0, 32'h00FFEA5C);
      exp_wr(3'd6, 32'h1);
      wait_done("t1");
      compare_writes("t1");
      check_val("t1_err",      32'(bus.err),     32'd0);
      check_val("t1_hold_idx", 32'(bus.pgm_idx), 32'd6);
      check_val("t1_hold_in",  bus.pgm_in,       32'h1);
      tick();
      check_val("t1_done_pulse", 32'(bus.done), 32'd0);

      // Bad header, its 4 bytes discarded, then a good record
      pulse_load();
      send_byte(8'h28);
      check_val("t2_err", 32'(bus.err), 32'd1);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_rec(8'h01, 32'hAABBCCDD);
      do_commit();
`ifdef CHEAT_PGM_ATOMIC_EN
      exp_wr(3'd6, 32'h0);
      exp_wr(3'd1, 32'hAABBCCDD);
      exp_wr(3'd6, 32'h1);
`else
      exp_wr(3'd1, 32'hAABBCCDD);
`endif
      wait_done("t2");
      compare_writes("t2");
      check_val("t2_err_sticky", 32'(bus.err), 32'd1);
      pulse_load();
      check_val("t2_err_clr", 32'(bus.err), 32'd0);
      do_commit();
      check_val("t2e_done", 32'(bus.done), 32'd1);
      check_val("t2e_busy", 32'(bus.busy), 32'd0);
      tick();
      check_val("t2e_done_pulse", 32'(bus.done), 32'd0);
      compare_writes("t2e");

      // Commit after 2 of 4 data bytes
      pulse_load();
      send_rec(8'h03, 32'h12345678);
      send_byte(8'h02); send_byte(8'hDE); send_byte(8'hAD);
      do_commit();
      check_val("t3_err", 32'(bus.err), 32'd1);
`ifdef CHEAT_PGM_ATOMIC_EN
      exp_wr(3'd6, 32'h0);
      exp_wr(3'd3, 32'h12345678);
      exp_wr(3'd6, 32'h1);
`else
      exp_wr(3'd3, 32'h12345678);
`endif
      wait_done("t3");
      compare_writes("t3");

      // Ctrl only; a byte arriving mid-commit flags err
      pulse_load();
      check_val("t4_err_clr", 32'(bus.err), 32'd0);
      send_rec(8'h07, 32'h0000_00F1);
      do_commit();
      send_byte(8'h00);
      check_val("t4_err_busy_byte", 32'(bus.err), 32'd1);
      exp_wr(3'd7, 32'h0000_00F1);
      wait_done("t4");
      compare_writes("t4");

      // Reset during SLOTS
      pulse_load();
      send_rec(8'h00, 32'h0000_0011);
      send_rec(8'h04, 32'h0000_0022);
      send_rec(8'h05, 32'h0000_0033);
      do_commit();
`ifdef CHEAT_PGM_ATOMIC_EN
      need = 2;
`else
      need = 1;
`endif
      got_n = 0;
      for (int i = 0; i < 200; i++) begin
         if (got_idx.size() >= need) begin
            got_n = got_idx.size();
            break;
         end
         tick();
      end
      check_val("t5_reached_slots", 32'(got_n), 32'(need));
      rst_n = 1'b0;
      #1;
      check_val("t5_rst_we",   32'(bus.pgm_we), 32'd0);
      check_val("t5_rst_busy", 32'(bus.busy),   32'd0);
      tick(); tick();
      rst_n = 1'b1;
      got_idx.delete(); got_word.delete();
      tick();
      pulse_load();
      send_rec(8'h01, 32'h0000_0055);
      do_commit();
`ifdef CHEAT_PGM_ATOMIC_EN
      exp_wr(3'd6, 32'h0);
      exp_wr(3'd1, 32'h55);
      exp_wr(3'd6, 32'h0);
`else
      exp_wr(3'd1, 32'h55);
`endif
      wait_done("t5");
      compare_writes("t5");

      // Slots 2 and 5, mask clean; slot 2 rewritten (last value wins)
      pulse_load();
      send_rec(8'h02, 32'h0000_1111);
      send_rec(8'h05, 32'h00D4E5F6);
      send_rec(8'h02, 32'h00A1B2C3);
      do_commit();
`ifdef CHEAT_PGM_ATOMIC_EN
      exp_wr(3'd6, 32'h0);
      exp_wr(3'd2, 32'h00A1B2C3);
      exp_wr(3'd5, 32'h00D4E5F6);
      exp_wr(3'd6, 32'h0);
`else
      exp_wr(3'd2, 32'h00A1B2C3);
      exp_wr(3'd5, 32'h00D4E5F6);
`endif
      wait_done("t6");
      compare_writes("t6");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
